// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter feeding a UART TX AXI-Stream port; optional stall timeout via UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int num_req_p = 2,
  parameter int data_width_p = 8,
  parameter int timeout_p = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic [num_req_p*data_width_p-1:0] s_axis_tdata_i,
  input  logic [num_req_p-1:0]              s_axis_tvalid_i,
  input  logic [num_req_p-1:0]              s_axis_tlast_i,
  output logic [num_req_p-1:0]              s_axis_tready_o,
  output logic [data_width_p-1:0]           m_axis_tdata_o,
  output logic                              m_axis_tvalid_o,
  output logic                              m_axis_tlast_o,
  input  logic                              m_axis_tready_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              timeout_o
);
  localparam int iw = $clog2(num_req_p);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [iw-1:0] last_r, pick, cand;
  logic found, out_ready, accept, sel_last, stall_hit;
  logic [data_width_p-1:0] sel_data;
  assign out_ready = !m_axis_tvalid_o || m_axis_tready_i;
  assign s_axis_tready_o = grant_o & {num_req_p{out_ready}};
  assign accept = |(s_axis_tvalid_i & s_axis_tready_o);
  // select the beat offered by the granted requester
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < num_req_p; k++)
      if (grant_o[k]) begin
        sel_data = s_axis_tdata_i[k*data_width_p +: data_width_p];
        sel_last = s_axis_tlast_i[k];
      end
  end
  // first valid requester scanning upward from the one after last_r
  always_comb begin
    pick = last_r;
    found = 1'b0;
    cand = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand = iw'((int'(last_r) + i) % num_req_p);
      if (!found && s_axis_tvalid_i[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic granted_valid;
  assign granted_valid = |(s_axis_tvalid_i & grant_o);
  assign stall_hit = state == GRANT && !granted_valid && stall_cnt == 16'(timeout_p - 1);
  // count cycles the granted requester leaves its valid low; downstream backpressure never counts
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= stall_hit;
      stall_cnt <= (state != GRANT || accept) ? '0 : (!granted_valid ? stall_cnt + 16'd1 : stall_cnt);
    end
`else
  assign stall_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // arbitration FSM plus the single-entry output register
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= IDLE;
      last_r <= iw'(num_req_p - 1);
      grant_o <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o <= '0;
      m_axis_tlast_o <= 1'b0;
    end else begin
      if (accept) begin
        m_axis_tvalid_o <= 1'b1;
        m_axis_tdata_o <= sel_data;
        m_axis_tlast_o <= sel_last;
      end else if (m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
      if (state == IDLE && |s_axis_tvalid_i) begin
        state <= GRANT;
        last_r <= pick;
        grant_o <= {{(num_req_p-1){1'b0}}, 1'b1} << pick;
      end else if (state == GRANT && ((accept && sel_last) || stall_hit)) begin
        state <= IDLE;
        grant_o <= '0;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized, model-checked bench for uart_tx_arbiter with three requesters
module tb_uart_tx_arbiter;
  localparam int n = 3;
  localparam int w = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int to = 8;
`else
  localparam int to = 1024;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [n*w-1:0] s_tdata = '0;
  logic [n-1:0] s_tvalid = '0, s_tlast = '0, s_tready, grant;
  logic [w-1:0] m_data;
  logic m_valid, m_last, m_ready = 1'b0, tout;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.num_req_p(n), .data_width_p(w), .timeout_p(to)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tlast_o(m_last),
    .m_axis_tready_i(m_ready), .grant_o(grant), .timeout_o(tout)
  );
  typedef struct {int step; logic [n-1:0] tready, grant; logic m_valid, m_ready, m_last, tout; logic [7:0] m_data;} obs_t;
  typedef struct {int step; logic [7:0] data; logic last;} out_t;
  logic [8:0] src_q [n][$];
  obs_t obs[$];
  out_t out_q[$];
  logic [n-1:0] pend = '0;
  int gap_pct = 0;
  int nstep = 0;
  int checks = 0;
  int errors = 0;
  // one clock: drive at negedge, sample just before posedge, retire handshaken beats
  task automatic step(input logic mr);
    obs_t o;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (!pend[k] && src_q[k].size() > 0 && $urandom_range(0, 99) >= gap_pct) pend[k] = 1'b1;
      s_tvalid[k] = pend[k];
      s_tdata[k*w +: w] = pend[k] ? src_q[k][0][7:0] : 8'h00;
      s_tlast[k] = pend[k] && src_q[k][0][8];
    end
    m_ready = mr;
    #4;
    o.step = nstep; o.tready = s_tready; o.grant = grant; o.m_valid = m_valid;
    o.m_ready = m_ready; o.m_last = m_last; o.tout = tout; o.m_data = m_data;
    obs.push_back(o);
    for (int k = 0; k < n; k++)
      if (s_tvalid[k] && s_tready[k]) begin
        void'(src_q[k].pop_front());
        pend[k] = 1'b0;
      end
    nstep++;
    @(posedge clk);
  endtask
  task automatic clear_stim();
    for (int k = 0; k < n; k++) src_q[k].delete();
    pend = '0;
    s_tvalid = '0;
    s_tlast = '0;
    obs.delete();
    nstep = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_stim();
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic void get_outs();
    out_t t;
    out_q.delete();
    foreach (obs[i])
      if (obs[i].m_valid && obs[i].m_ready) begin
        t.step = obs[i].step; t.data = obs[i].m_data; t.last = obs[i].m_last;
        out_q.push_back(t);
      end
  endfunction
  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({grant, s_tready, m_valid, m_data, m_last, tout} !== '0) begin
      errors++;
      $display("FAIL reset_during: got %b required all zero", {grant, s_tready, m_valid, m_data, m_last, tout});
    end
    do_reset();
    repeat (2) step(1'b1);
    checks++;
    if (obs[1].grant !== '0 || obs[1].m_valid !== 1'b0 || obs[1].tready !== '0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b valid=%b tready=%b required 0", obs[1].grant, obs[1].m_valid, obs[1].tready);
    end
  endtask
  task automatic test_single();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    foreach (exp_d[j]) src_q[0].push_back({j == 3, exp_d[j]});
    repeat (8) step(1'b1);
    checks++;
    if (obs[0].grant !== 3'b000 || obs[1].grant !== 3'b001 || obs[1].tready !== 3'b001) begin
      errors++;
      $display("FAIL single_arb: grant0=%b grant1=%b tready1=%b required 000 001 001", obs[0].grant, obs[1].grant, obs[1].tready);
    end
    get_outs();
    checks++;
    if (out_q.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d beats required 4", out_q.size());
    end
    for (int j = 0; j < 4 && j < out_q.size(); j++) begin
      checks++;
      if (out_q[j].step != 2 + j || out_q[j].data !== exp_d[j] || out_q[j].last !== (j == 3)) begin
        errors++;
        $display("FAIL single_beat%0d: step=%0d data=%h last=%b required step=%0d data=%h last=%b",
                 j, out_q[j].step, out_q[j].data, out_q[j].last, 2 + j, exp_d[j], j == 3);
      end
    end
    checks++;
    if (obs[6].grant !== '0) begin
      errors++;
      $display("FAIL single_release: grant=%b required 000", obs[6].grant);
    end
  endtask
  task automatic test_round_robin();
    int ow, pk;
    do_reset();
    for (int k = 0; k < n; k++)
      for (int s = 0; s < 4; s++) src_q[k].push_back({s[0], 2'(k), 6'(s)});
    repeat (24) step(1'b1);
    get_outs();
    checks++;
    if (out_q.size() != 12) begin
      errors++;
      $display("FAIL rr_count: got %0d beats required 12", out_q.size());
    end
    for (int j = 0; j < 12 && j < out_q.size(); j++) begin
      pk = j / 2;
      ow = pk % n;
      checks++;
      if (out_q[j].data !== {2'(ow), 6'((pk / n) * 2 + j % 2)} || out_q[j].last !== (j % 2 == 1) || out_q[j].step != 2 + 3 * pk + j % 2) begin
        errors++;
        $display("FAIL rr_beat%0d: step=%0d data=%h last=%b required step=%0d data=%h last=%b", j, out_q[j].step,
                 out_q[j].data, out_q[j].last, 2 + 3 * pk + j % 2, {2'(ow), 6'((pk / n) * 2 + j % 2)}, j % 2 == 1);
      end
    end
  endtask
  task automatic test_backpressure();
    logic mr_pat [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [7:0] exp_d [3] = '{8'hA0, 8'hA1, 8'hA2};
    do_reset();
    foreach (exp_d[j]) src_q[0].push_back({j == 2, exp_d[j]});
    foreach (mr_pat[i]) step(mr_pat[i]);
    get_outs();
    checks++;
    if (out_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d beats required 3", out_q.size());
    end
    for (int j = 0; j < 3 && j < out_q.size(); j++) begin
      checks++;
      if (out_q[j].data !== exp_d[j] || out_q[j].last !== (j == 2)) begin
        errors++;
        $display("FAIL bp_beat%0d: data=%h last=%b required %h %b", j, out_q[j].data, out_q[j].last, exp_d[j], j == 2);
      end
    end
    for (int i = 0; i + 1 < obs.size(); i++)
      if (obs[i].m_valid && !obs[i].m_ready) begin
        checks++;
        if (!obs[i+1].m_valid || obs[i+1].m_data !== obs[i].m_data || obs[i].tready !== '0) begin
          errors++;
          $display("FAIL bp_hold step%0d: next valid=%b data=%h tready=%b required 1 %h 000", i,
                   obs[i+1].m_valid, obs[i+1].m_data, obs[i].tready, obs[i].m_data);
        end
      end
  endtask
  task automatic test_random();
    logic [8:0] exp_s [n][$];
    logic [8:0] got_s [n][$];
    int owner, ow, len, seq;
    bit done;
    do_reset();
    gap_pct = 30;
    for (int k = 0; k < n; k++) begin
      seq = 0;
      repeat ($urandom_range(2, 4)) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          src_q[k].push_back({b == len - 1, 2'(k), 6'(seq)});
          exp_s[k].push_back({b == len - 1, 2'(k), 6'(seq)});
          seq++;
        end
      end
    end
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step($urandom_range(0, 2) != 0);
      done = pend == '0 && src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_budget: sources not drained within 3000 cycles");
    end
    repeat (4) step(1'b1);
    gap_pct = 0;
    get_outs();
    owner = -1;
    foreach (out_q[j]) begin
      ow = int'(out_q[j].data[7:6]);
      if (owner >= 0) begin
        checks++;
        if (ow != owner) begin
          errors++;
          $display("FAIL rand_interleave beat%0d: owner=%0d required %0d", j, ow, owner);
        end
      end else owner = ow;
      if (ow < n) got_s[ow].push_back({out_q[j].last, out_q[j].data});
      if (out_q[j].last) owner = -1;
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_s[k].size() != exp_s[k].size()) begin
        errors++;
        $display("FAIL rand_count req%0d: got %0d beats required %0d", k, got_s[k].size(), exp_s[k].size());
      end
      for (int j = 0; j < got_s[k].size() && j < exp_s[k].size(); j++) begin
        checks++;
        if (got_s[k][j] !== exp_s[k][j]) begin
          errors++;
          $display("FAIL rand_beat req%0d #%0d: got %h required %h", k, j, got_s[k][j], exp_s[k][j]);
        end
      end
    end
    for (int i = 0; i + 1 < obs.size(); i++) begin
      checks++;
      if (!$onehot0(obs[i].tready) || (obs[i].tready & ~obs[i].grant) != '0 || (obs[i].m_valid && !obs[i].m_ready &&
          (obs[i].tready != '0 || !obs[i+1].m_valid || obs[i+1].m_data !== obs[i].m_data))) begin
        errors++;
        $display("FAIL rand_handshake step%0d: tready=%b grant=%b valid=%b ready=%b data=%h next=%h", i, obs[i].tready,
                 obs[i].grant, obs[i].m_valid, obs[i].m_ready, obs[i].m_data, obs[i+1].m_data);
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int j = 0; j < 4; j++) src_q[0].push_back({j == 3, 8'(8'hB0 + j)});
    repeat (3) step(1'b1);
    #2;
    rst_n = 1'b0;
    clear_stim();
    #1;
    checks++;
    if (m_valid !== 1'b0 || grant !== '0 || s_tready !== '0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b grant=%b tready=%b required 0", m_valid, grant, s_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    src_q[1].push_back({1'b1, 8'h55});
    repeat (5) step(1'b1);
    checks++;
    if (obs[1].grant !== 3'b010) begin
      errors++;
      $display("FAIL midreset_regrant: grant=%b required 010", obs[1].grant);
    end
    get_outs();
    checks++;
    if (out_q.size() != 1 || out_q[0].data !== 8'h55) begin
      errors++;
      $display("FAIL midreset_truncate: got %0d beats first=%h required 1 beat 55", out_q.size(),
               out_q.size() > 0 ? out_q[0].data : 8'h00);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    src_q[0].push_back({1'b0, 8'h10});
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (14) step(1'b1);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (obs[i].tout !== (i == 10)) begin
        errors++;
        $display("FAIL timeout_pulse step%0d: got %b required %b", i, obs[i].tout, i == 10);
      end
    end
    checks++;
    if (obs[10].grant !== '0) begin
      errors++;
      $display("FAIL timeout_release: grant=%b required 000", obs[10].grant);
    end
    src_q[0].push_back({1'b1, 8'h20});
    src_q[1].push_back({1'b1, 8'h30});
    repeat (4) step(1'b1);
    checks++;
    if (obs[15].grant !== 3'b010) begin
      errors++;
      $display("FAIL timeout_next: grant=%b required 010", obs[15].grant);
    end
`else
    repeat (101) step(1'b1);
    for (int i = 1; i <= 100; i++) begin
      checks++;
      if (obs[i].grant !== 3'b001 || obs[i].tout !== 1'b0) begin
        errors++;
        $display("FAIL hold_grant step%0d: grant=%b timeout=%b required 001 0", i, obs[i].grant, obs[i].tout);
      end
    end
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
